mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
Two-requester round-robin arbiter that owns the select of the team's 2:1 multiplexer datapath and shares one downstream channel between requester 0 (x side) and requester 1 (y side).
- Registers the grant and drives the mux select.
- Applies a valid/ready handshake toward the consumer.
- Bounds the number of consecutive transfers one requester may take while the other waits.
- Sits between two producer blocks and a single consumer.

Parameters:
WIDTH, 8, data width of each requester and of the output channel
MAX_BURST, 4, max consecutive transfers per grant while the other requester is pending (>=1; 1 = strict alternation)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the channel
data0  input  WIDTH  requester 0 data
req1  input  1  requester 1 wants the channel
data1  input  WIDTH  requester 1 data
out_ready  input  1  consumer accepts data this cycle
gnt0  output  1  requester 0 owns the channel
gnt1  output  1  requester 1 owns the channel
sel  output  1  mux select: 0 = data0 (x), 1 = data1 (y)
out_data  output  WIDTH  selected data
out_valid  output  1  out_data valid this cycle

Behaviour:
- One clock; reset is asynchronous and active-low: resetn low immediately forces state=IDLE, burst count cnt=0, priority pointer prio=0.
- Reset output values: gnt0=0, gnt1=0, sel=0, out_valid=0, out_data=data0 (combinational through sel=0).
- State machine states: IDLE, G0, G1. Outputs are Moore from state:
  - gnt0 = (state==G0)
  - gnt1 = (state==G1)
  - sel = (state==G1)
- out_data = sel ? data1 : data0, purely combinational, same function as the 2:1 mux, per bit.
- out_valid = (G0 & req0) | (G1 & req1).
- Transfer (xfer) = out_valid & out_ready.
- IDLE transitions:
  - req0 & req1 -> G0 if prio==0, else G1
  - req0 only -> G0
  - req1 only -> G1
  - neither -> stay in IDLE
- G0 transitions (G1 is symmetric with 0 and 1 swapped):
  - req0 low -> G1 if req1 high (direct handoff, no IDLE bubble), else IDLE
  - else xfer & (cnt==MAX_BURST-1) & req1 -> G1
  - else stay in G0
- prio: on leaving G0, prio<=1; on leaving G1, prio<=0. prio is unchanged otherwise.
- cnt:
  - cleared on every state change
  - incremented on xfer while the state is held
  - saturates at MAX_BURST-1 when the other requester is idle, so the first xfer after the other requester raises req causes the switch
- Latency:
  - req to gnt: 1 cycle from IDLE
  - out_valid in the same cycle gnt is high, provided req is still high
  - a switch after the limiting xfer takes effect the next cycle, with no dead cycle
- Requester rules:
  - data must be held stable while req & gnt & !out_ready
  - req may drop at any time; a dropped req cancels that cycle's valid
  - data is consumed only on xfer
- Backpressure: out_ready low never changes state or cnt, except for the req-drop release paths.
- Simultaneous events: when req0 drops in the same cycle that the burst limit is reached, the next state is G1 when req1 is high (both rules agree), otherwise IDLE.
- Reset mid-transfer: grant is lost immediately, out_valid=0, no transfer is recorded. After release, arbitration restarts from IDLE with prio=0.
- Grant never changes while out_valid & !out_ready except via req drop; valid data is never switched away under backpressure.

Test Plan:
- Reset: resetn=0 with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0. Release resetn -> next edge gnt0=1, sel=0, out_valid=1.
- Single requester, WIDTH=8: req1=1, data1=8'hA5, req0=0, out_ready=1 -> gnt1 one cycle later, sel=1, out_data=8'hA5. gnt1 is held for 10 transfers; no forced switch because req0 is low.
- Fairness, MAX_BURST=4: req0=req1=1, out_ready=1 constant -> grant pattern G0 x4, G1 x4, G0 x4, with gnt0/gnt1 never both high and no idle cycles.
- Backpressure: in G0 with cnt=3 and req1=1, hold out_ready=0 for 5 cycles -> gnt0 stays high, out_data stable. Raise out_ready -> one xfer, then gnt1=1 on the next cycle.
- Handoff: in G0, drop req0 while req1=1 -> gnt1=1 next cycle, prio=1. Then drop req1 -> IDLE, gnt0=gnt1=0.
- Mid-burst reset: in G1 with cnt=2, pulse resetn low asynchronously between edges -> gnt1 falls without a clock edge. After release with both requesting, G0 is granted first.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 data mux.
// Grants are bounded by MAX_BURST consecutive transfers while the other side waits.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  // state | meaning
  // IDLE  | no grant, waiting for a request
  // G0    | requester 0 (x side) owns the channel
  // G1    | requester 1 (y side) owns the channel
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          prio;
  logic          xfer;
  logic          at_limit;

  assign xfer     = out_valid & out_ready;
  assign at_limit = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (xfer && !at_limit)
        cnt <= cnt + 1'b1;
      // Priority points at whoever did not just give up the channel.
      if (state == G0 && state_nxt != G0)
        prio <= 1'b1;
      else if (state == G1 && state_nxt != G1)
        prio <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = prio ? G1 : G0;
        else if (req0)
          state_nxt = G0;
        else if (req1)
          state_nxt = G1;
      end
      G0: begin
        if (!req0)
          state_nxt = req1 ? G1 : IDLE;
        else if (xfer && at_limit && req1)
          state_nxt = G1;
      end
      G1: begin
        if (!req1)
          state_nxt = req0 ? G0 : IDLE;
        else if (xfer && at_limit && req0)
          state_nxt = G0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = (state == G0);
    gnt1      = (state == G1);
    sel       = (state == G1);
    out_valid = (gnt0 & req0) | (gnt1 & req1);
    out_data  = sel ? data1 : data0;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed per-cycle vector bench for mux_arbiter plus hand-written reset/handoff sequences.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0, req1, out_ready;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .out_ready(out_ready),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_data(out_data), .out_valid(out_valid)
  );

  typedef struct {
    logic       rstn, r0, r1, rdy;
    logic [7:0] d0, d1;
    logic       g0, g1, s, v;
    logic [7:0] od;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstn, r0, r1, rdy, input logic [7:0] d0, d1,
                     input logic g0, g1, s, v, input logic [7:0] od);
    vec_t t;
    t.rstn = rstn; t.r0 = r0; t.r1 = r1; t.rdy = rdy; t.d0 = d0; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.s = s; t.v = v; t.od = od;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t t);
    string n;
    n = $sformatf("vec%0d", i);
    chk({n, ".gnt0"}, {7'd0, gnt0}, {7'd0, t.g0});
    chk({n, ".gnt1"}, {7'd0, gnt1}, {7'd0, t.g1});
    chk({n, ".sel"}, {7'd0, sel}, {7'd0, t.s});
    chk({n, ".out_valid"}, {7'd0, out_valid}, {7'd0, t.v});
    chk({n, ".out_data"}, out_data, t.od);
  endtask

  initial begin
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    data0 = 8'h00; data1 = 8'h00;

    // Reset held with both requesting, then release: IDLE this cycle.
    add(0,1,1,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    add(1,1,1,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    // Fairness: G0 x4, G1 x4, G0 x4, G1 once.
    for (int i = 0; i < 4; i++) add(1,1,1,1, 8'h3C,8'hA5, 1,0,0,1, 8'h3C);
    for (int i = 0; i < 4; i++) add(1,1,1,1, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    for (int i = 0; i < 4; i++) add(1,1,1,1, 8'hC3,8'h5A, 1,0,0,1, 8'hC3);
    // G1 entered; both drop -> valid cancelled, then IDLE.
    add(1,0,0,1, 8'h3C,8'hA5, 0,1,1,0, 8'hA5);
    add(1,0,0,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    // Single requester 1: grant one cycle later, held for 10 transfers.
    add(1,0,1,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    for (int i = 0; i < 10; i++) add(1,0,1,1, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    // Backpressure at saturated cnt with req0 pending: 5 stalled cycles, then one xfer.
    for (int i = 0; i < 5; i++) add(1,1,1,0, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    add(1,1,1,1, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    // Switched to G0 with no dead cycle; drop req0 with req1 high -> direct handoff.
    add(1,0,1,1, 8'h3C,8'hA5, 1,0,0,0, 8'h3C);
    add(1,0,1,1, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    add(1,0,0,1, 8'h3C,8'hA5, 0,1,1,0, 8'hA5);
    // IDLE; req0 alone -> G0, drop req0 -> IDLE with prio=1, then both -> G1 first.
    add(1,1,0,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    add(1,0,0,1, 8'h3C,8'hA5, 1,0,0,0, 8'h3C);
    add(1,1,1,1, 8'h3C,8'hA5, 0,0,0,0, 8'h3C);
    for (int i = 0; i < 3; i++) add(1,1,1,1, 8'h3C,8'hA5, 0,1,1,1, 8'hA5);
    // At the burst limit req1 drops: valid cancelled, release to G0.
    add(1,1,0,1, 8'h3C,8'hA5, 0,1,1,0, 8'hA5);
    add(1,1,0,1, 8'h3C,8'hA5, 1,0,0,1, 8'h3C);

    foreach (vecs[i]) begin
      @(negedge clk);
      resetn = vecs[i].rstn; req0 = vecs[i].r0; req1 = vecs[i].r1;
      out_ready = vecs[i].rdy; data0 = vecs[i].d0; data1 = vecs[i].d1;
      #1;
      chk_vec(i, vecs[i]);
    end

    // Mid-burst async reset: reach G1 with cnt=2.
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; out_ready = 1'b1; data1 = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset.gnt1", {7'd0, gnt1}, 8'd1);
    resetn = 1'b0;
    #1;
    chk("async_reset.gnt1", {7'd0, gnt1}, 8'd0);
    chk("async_reset.out_valid", {7'd0, out_valid}, 8'd0);
    chk("async_reset.sel", {7'd0, sel}, 8'd0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset.gnt0", {7'd0, gnt0}, 8'd1);
    chk("post_reset.gnt1", {7'd0, gnt1}, 8'd0);
    chk("post_reset.out_valid", {7'd0, out_valid}, 8'd1);

    // Drop req0: bounded wait for the handoff to requester 1.
    req0 = 1'b0;
    begin
      int n;
      n = 0;
      while (gnt1 !== 1'b1 && n < 4) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("handoff.gnt1", {7'd0, gnt1}, 8'd1);
      chk("handoff.latency", 8'(n), 8'd1);
      chk("handoff.out_data", out_data, 8'h77);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
